// File: rtl/mips_pkg.sv
// mips_pkg: shared types for the MEM-stage access controller.
// Holds the controller state enum and the default access timeout.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_t;

  localparam int unsigned MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: MEM-stage request inputs, memory bus and
// pipeline control outputs of the access controller.
//   slave  : controller side (pipeline/memory in, request/stall out)
//   master : pipeline + memory side
interface mem_access_ctrl_if;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        wb_bubble;
  logic [31:0] read_data;
  logic        err;

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    input  mem_ready, mem_rdata,
    output req_valid, req_we, req_addr, req_wdata,
    output stall, wb_bubble, read_data, err
  );

  modport master (
    output mem_read, mem_write, addr, wdata,
    output mem_ready, mem_rdata,
    input  req_valid, req_we, req_addr, req_wdata,
    input  stall, wb_bubble, read_data, err
  );

endinterface

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: 8-bit ACCESS-cycle counter for the access timeout.
// Ports: clk, reset (async high), clear, en, limit[7:0], expired.
module mem_timeout_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 8'd0;
    end else if (clear) begin
      r_cnt <= 8'd0;
    end else if (en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // r_cnt counts completed wait cycles, so the current cycle
  // is the limit-th one when r_cnt is one short of limit.
  assign expired = (r_cnt == limit - 8'd1);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store controller with stall,
// writeback bubble, misalignment check and access timeout.
// Ports: clk, reset (async high), bus (mem_access_ctrl_if.slave).
module mem_access_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEF
) (
  input logic              clk,
  input logic              reset,
  mem_access_ctrl_if.slave bus
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  mem_state_t  r_state;
  mem_state_t  w_next;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_req;
  logic        w_mis;
  logic        w_clr;
  logic        w_en;
  logic        w_exp;
  logic        w_stall;

  assign w_req = bus.mem_read | bus.mem_write;
  assign w_mis = bus.addr[1:0] != 2'b00;

  mem_timeout_cnt u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_clr),
    .en     (w_en),
    .limit  (LIMIT),
    .expired(w_exp)
  );

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_en   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next = w_mis ? DONE : ACCESS;
          w_clr  = !w_mis;
        end
      end
      ACCESS: begin
        if (bus.mem_ready) begin
          w_next = DONE;
        end else begin
          w_en = 1'b1;
          if (w_exp) w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_we    <= bus.mem_write;
            if (w_mis) begin
              r_rdata <= 32'd0;
              r_err   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // ready beats a same-cycle timeout
          if (bus.mem_ready) begin
            r_rdata <= r_we ? 32'd0 : bus.mem_rdata;
          end else if (w_exp) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stall is raised in the request cycle itself, before the
  // state register has moved, and is forced low under reset.
  assign w_stall = !reset &&
    ((r_state == IDLE && w_req) || r_state == ACCESS);

  assign bus.stall     = w_stall;
  assign bus.wb_bubble = w_stall;
  assign bus.req_valid = (r_state == ACCESS);
  assign bus.req_we    = r_we;
  assign bus.req_addr  = r_addr;
  assign bus.req_wdata = r_wdata;
  assign bus.read_data = r_rdata;
  assign bus.err       = r_err;

endmodule
